// File: rtl/control_pkg.sv
// Shared opcodes, control-word bit map and decoded-word constants for the control pipeline.
package control_pkg;

  localparam int unsigned OPW = 6;
  localparam int unsigned CW  = 10;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_NOT   = 6'b111111;
  localparam logic [OPW-1:0] OP_BR2   = 6'b111110;

  localparam int unsigned CTL_SALTOINCOND = 9;
  localparam int unsigned CTL_REGDEST     = 8;
  localparam int unsigned CTL_FUENTEALU   = 7;
  localparam int unsigned CTL_MEMAREG     = 6;
  localparam int unsigned CTL_ESCRREG     = 5;
  localparam int unsigned CTL_LEERMEM     = 4;
  localparam int unsigned CTL_ESCRMEM     = 3;
  localparam int unsigned CTL_SALTOCOND   = 2;
  localparam int unsigned CTL_ALUOP_MSB   = 1;
  localparam int unsigned CTL_ALUOP_LSB   = 0;

  localparam logic [CW-1:0] CTL_RTYPE  = 10'b0100100010;
  localparam logic [CW-1:0] CTL_LW     = 10'b0011110000;
  localparam logic [CW-1:0] CTL_SW     = 10'b0010001000;
  localparam logic [CW-1:0] CTL_BEQ    = 10'b0000000101;
  localparam logic [CW-1:0] CTL_NOT    = 10'b0010100000;
  localparam logic [CW-1:0] CTL_BR2    = 10'b0000000101;
  localparam logic [CW-1:0] CTL_BUBBLE = '0;

endpackage

// File: rtl/control_pipe_if.sv
// ID-side bundle of the control pipeline: opcode/register fields and controls in,
// staged control words, valids and hazard/illegal flags out.
interface control_pipe_if #(
  parameter int unsigned OPW     = 6,
  parameter int unsigned CW      = 10,
  parameter int unsigned REGW    = 5,
  parameter int unsigned NSTAGES = 3
);
  logic [OPW-1:0]        opcode_i;
  logic [REGW-1:0]       id_rs_i;
  logic [REGW-1:0]       id_rt_i;
  logic                  stall_i;
  logic                  flush_i;
  logic [NSTAGES*CW-1:0] ctrl_stages_o;
  logic [NSTAGES-1:0]    valid_o;
  logic                  hazard_stall_o;
  logic                  illegal_o;

  modport master (
    output opcode_i, id_rs_i, id_rt_i, stall_i, flush_i,
    input  ctrl_stages_o, valid_o, hazard_stall_o, illegal_o
  );

  modport slave (
    input  opcode_i, id_rs_i, id_rt_i, stall_i, flush_i,
    output ctrl_stages_o, valid_o, hazard_stall_o, illegal_o
  );
endinterface

// File: rtl/control_decode.sv
// Combinational main decoder: opcode -> 10-bit control word plus illegal flag.
module control_decode
  import control_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output logic [CW-1:0]  ctrl_o,
  output logic           illegal_o
);

  always_comb begin
    ctrl_o    = CTL_BUBBLE;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: ctrl_o = CTL_RTYPE;
      OP_LW:    ctrl_o = CTL_LW;
      OP_SW:    ctrl_o = CTL_SW;
      OP_BEQ:   ctrl_o = CTL_BEQ;
      OP_NOT:   ctrl_o = CTL_NOT;
      OP_BR2:   ctrl_o = CTL_BR2;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Decoder plus NSTAGES-deep control-word pipeline with bubble/flush/freeze handling.
// Load-use detection against stage 0 is built only when CONTROL_PIPE_HAZARD_EN is defined.
module control_pipe #(
  parameter int unsigned OPW     = 6,
  parameter int unsigned CW      = 10,
  parameter int unsigned REGW    = 5,
  parameter int unsigned NSTAGES = 3
) (
  input logic           clk,
  input logic           rst_n,
  control_pipe_if.slave bus
);
  import control_pkg::CTL_LEERMEM;
  import control_pkg::CTL_BUBBLE;

  logic [OPW-1:0]     w_opcode;
  logic [CW-1:0]      w_dec_word;
  logic               w_dec_illegal;
  logic               w_hazard;
  logic [CW-1:0]      r_stage     [NSTAGES];
  logic [CW-1:0]      w_stage_nxt [NSTAGES];
  logic [NSTAGES-1:0] r_valid, w_valid_nxt;
  logic               r_illegal, w_illegal_nxt;

  assign w_opcode = bus.opcode_i;

  control_decode u_decode (
    .opcode_i  (w_opcode),
    .ctrl_o    (w_dec_word),
    .illegal_o (w_dec_illegal)
  );

`ifdef CONTROL_PIPE_HAZARD_EN
  logic [REGW-1:0] r_ex_rt, w_ex_rt_nxt;

  // No $0 exemption: a load targeting register 0 still stalls a consumer of $0.
  assign w_hazard = r_valid[0] & r_stage[0][CTL_LEERMEM]
                  & ((r_ex_rt == bus.id_rs_i) | (r_ex_rt == bus.id_rt_i)) & ~bus.flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex_rt <= '0;
    else        r_ex_rt <= w_ex_rt_nxt;
  end
`else
  logic [REGW-1:0] w_unused_rs, w_unused_rt;
  assign w_unused_rs = bus.id_rs_i;
  assign w_unused_rt = bus.id_rt_i;
  assign w_hazard    = 1'b0;
`endif

  always_comb begin
    w_stage_nxt   = r_stage;
    w_valid_nxt   = r_valid;
    w_illegal_nxt = 1'b0;
`ifdef CONTROL_PIPE_HAZARD_EN
    w_ex_rt_nxt   = r_ex_rt;
`endif
    // Freeze wins over flush and hazard: nothing moves.
    if (!bus.stall_i) begin
      for (int k = 1; k < NSTAGES; k++) begin
        w_stage_nxt[k] = r_stage[k-1];
        w_valid_nxt[k] = r_valid[k-1];
      end
      if (bus.flush_i || w_hazard) begin
        w_stage_nxt[0] = CTL_BUBBLE;
        w_valid_nxt[0] = 1'b0;
      end else begin
        w_stage_nxt[0] = w_dec_word;
        w_valid_nxt[0] = 1'b1;
        w_illegal_nxt  = w_dec_illegal;
`ifdef CONTROL_PIPE_HAZARD_EN
        w_ex_rt_nxt    = bus.id_rt_i;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) r_stage[k] <= '0;
      r_valid   <= '0;
      r_illegal <= 1'b0;
    end else begin
      for (int k = 0; k < NSTAGES; k++) r_stage[k] <= w_stage_nxt[k];
      r_valid   <= w_valid_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  always_comb begin
    bus.ctrl_stages_o = '0;
    for (int k = 0; k < NSTAGES; k++) bus.ctrl_stages_o[k*CW +: CW] = r_stage[k];
  end

  assign bus.valid_o        = r_valid;
  assign bus.illegal_o      = r_illegal;
  assign bus.hazard_stall_o = w_hazard;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: reference decode table plus a stage model,
// with stage-0 results queued at drive time and compared after each edge.
module tb_control_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  control_pipe_if #(.OPW(6), .CW(10), .REGW(5), .NSTAGES(3)) bus ();

  control_pipe #(.OPW(6), .CW(10), .REGW(5), .NSTAGES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       v;
    logic [9:0] w;
    logic       ill;
  } s0_t;

  int         n_vec = 0;
  int         n_err = 0;
  s0_t        sb[$];
  s0_t        got, exp_e;
  logic [9:0] m_stage [3];
  logic [2:0] m_valid;
  logic       m_ill;
  logic [4:0] m_ex_rt;
  logic       h_exp, h_obs;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BQ = 6'b000100;
  localparam logic [5:0] NT = 6'b111111, B2 = 6'b111110, IL = 6'b010101;

  function automatic logic [10:0] ref_dec(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b0, 10'b0100100010};
      6'b100011: return {1'b0, 10'b0011110000};
      6'b101011: return {1'b0, 10'b0010001000};
      6'b000100: return {1'b0, 10'b0000000101};
      6'b111111: return {1'b0, 10'b0010100000};
      6'b111110: return {1'b0, 10'b0000000101};
      default:   return {1'b1, 10'b0000000000};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_stage[k] = '0;
    m_valid = '0;
    m_ill   = 1'b0;
    m_ex_rt = '0;
    sb.delete();
  endtask

  // Drive one cycle of ID inputs, advance the model, queue the expected stage-0 result.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic st, input logic fl);
    logic [10:0] d;
    bus.opcode_i = op;
    bus.id_rs_i  = rs;
    bus.id_rt_i  = rt;
    bus.stall_i  = st;
    bus.flush_i  = fl;
    #1;
`ifdef CONTROL_PIPE_HAZARD_EN
    h_exp = m_valid[0] & m_stage[0][4] & ((m_ex_rt == rs) | (m_ex_rt == rt)) & ~fl;
`else
    h_exp = 1'b0;
`endif
    h_obs = bus.hazard_stall_o;
    d = ref_dec(op);
    m_ill = 1'b0;
    if (!st) begin
      m_stage[2] = m_stage[1]; m_valid[2] = m_valid[1];
      m_stage[1] = m_stage[0]; m_valid[1] = m_valid[0];
      if (fl || h_exp) begin
        m_stage[0] = '0;
        m_valid[0] = 1'b0;
      end else begin
        m_stage[0] = d[9:0];
        m_valid[0] = 1'b1;
        m_ill      = d[10];
        m_ex_rt    = rt;
      end
    end
    sb.push_back('{v: m_valid[0], w: m_stage[0], ill: m_ill});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.opcode_i = '0; bus.id_rs_i = '0; bus.id_rt_i = '0;
    bus.stall_i  = 1'b1; bus.flush_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({bus.ctrl_stages_o, bus.valid_o, bus.illegal_o, bus.hazard_stall_o} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_async: got stages=%b valid=%b ill=%b haz=%b, want all 0",
               bus.ctrl_stages_o, bus.valid_o, bus.illegal_o, bus.hazard_stall_o);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.ctrl_stages_o, bus.valid_o} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_release_stall: got stages=%b valid=%b, want 0",
               bus.ctrl_stages_o, bus.valid_o);
    end
  endtask

  task automatic test_decode();
    logic [5:0] ops [8] = '{RT, LW, SW, BQ, NT, B2, IL, 6'b000001};
    for (int i = 0; i < 8; i++) begin
      step(ops[i], 5'd20, 5'd21, 1'b0, 1'b0);
      exp_e = sb.pop_front();
      got   = '{v: bus.valid_o[0], w: bus.ctrl_stages_o[9:0], ill: bus.illegal_o};
      n_vec++;
      if (got !== exp_e || bus.ctrl_stages_o !== {m_stage[2], m_stage[1], m_stage[0]}) begin
        n_err++;
        $display("FAIL decode op=%b: got s0=%b v=%b ill=%b stages=%h, want s0=%b v=%b ill=%b",
                 ops[i], got.w, got.v, got.ill, bus.ctrl_stages_o, exp_e.w, exp_e.v, exp_e.ill);
      end
    end
  endtask

  task automatic test_flow();
    logic [5:0] ops [3] = '{RT, LW, SW};
    logic [4:0] rss [3] = '{5'd1, 5'd3, 5'd8};
    logic [4:0] rts [3] = '{5'd2, 5'd5, 5'd9};
    for (int i = 0; i < 3; i++) begin
      step(ops[i], rss[i], rts[i], 1'b0, 1'b0);
      exp_e = sb.pop_front();
      got   = '{v: bus.valid_o[0], w: bus.ctrl_stages_o[9:0], ill: bus.illegal_o};
      n_vec++;
      if (got !== exp_e || h_obs !== h_exp) begin
        n_err++;
        $display("FAIL flow[%0d]: got s0=%b v=%b haz=%b, want s0=%b v=%b haz=%b",
                 i, got.w, got.v, h_obs, exp_e.w, exp_e.v, h_exp);
      end
    end
    n_vec++;
    if (bus.ctrl_stages_o !== {10'b0100100010, 10'b0011110000, 10'b0010001000}
        || bus.valid_o !== 3'b111) begin
      n_err++;
      $display("FAIL flow_latency: got stages=%b valid=%b, want R/lw/sw valid 111",
               bus.ctrl_stages_o, bus.valid_o);
    end
  endtask

  task automatic test_load_use();
    step(LW, 5'd1, 5'd5, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(RT, 5'd5, 5'd0, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    n_vec++;
`ifdef CONTROL_PIPE_HAZARD_EN
    if (h_obs !== 1'b1 || bus.valid_o[0] !== 1'b0 || bus.ctrl_stages_o[9:0] !== 10'd0) begin
`else
    if (h_obs !== 1'b0 || bus.valid_o[0] !== 1'b1
        || bus.ctrl_stages_o[9:0] !== 10'b0100100010) begin
`endif
      n_err++;
      $display("FAIL load_use_hit: got haz=%b v0=%b s0=%b, want haz=%b v0=%b s0=%b",
               h_obs, bus.valid_o[0], bus.ctrl_stages_o[9:0], h_exp, exp_e.v, exp_e.w);
    end
    // Retry of the same consumer (or a plain follower when detection is absent).
    step(RT, 5'd5, 5'd0, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    got   = '{v: bus.valid_o[0], w: bus.ctrl_stages_o[9:0], ill: bus.illegal_o};
    n_vec++;
    if (h_obs !== 1'b0 || got !== exp_e || bus.valid_o !== m_valid) begin
      n_err++;
      $display("FAIL load_use_retry: got haz=%b s0=%b valid=%b, want haz=0 s0=%b valid=%b",
               h_obs, got.w, bus.valid_o, exp_e.w, m_valid);
    end
    step(LW, 5'd1, 5'd5, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(RT, 5'd6, 5'd7, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    n_vec++;
    if (h_obs !== 1'b0 || bus.valid_o[0] !== 1'b1 || bus.ctrl_stages_o[9:0] !== 10'b0100100010) begin
      n_err++;
      $display("FAIL load_use_miss: got haz=%b v0=%b s0=%b, want haz=0 v0=1 s0=0100100010",
               h_obs, bus.valid_o[0], bus.ctrl_stages_o[9:0]);
    end
    // lw to $0 followed by a $0 consumer.
    step(LW, 5'd2, 5'd0, 1'b0, 1'b0);
    void'(sb.pop_front());
    step(SW, 5'd0, 5'd9, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    got   = '{v: bus.valid_o[0], w: bus.ctrl_stages_o[9:0], ill: bus.illegal_o};
    n_vec++;
    if (h_obs !== h_exp || got !== exp_e) begin
      n_err++;
      $display("FAIL load_use_r0: got haz=%b s0=%b v0=%b, want haz=%b s0=%b v0=%b",
               h_obs, got.w, got.v, h_exp, exp_e.w, exp_e.v);
    end
    step(SW, 5'd0, 5'd9, 1'b0, 1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_flush_stall();
    step(LW, 5'd1, 5'd4, 1'b0, 1'b0);
    void'(sb.pop_front());
    // Matching consumer arriving with a flush: flush wins, no hazard.
    step(RT, 5'd4, 5'd4, 1'b0, 1'b1);
    exp_e = sb.pop_front();
    n_vec++;
    if (h_obs !== 1'b0 || bus.valid_o[0] !== 1'b0 || bus.ctrl_stages_o[9:0] !== 10'd0
        || bus.ctrl_stages_o[19:10] !== 10'b0011110000) begin
      n_err++;
      $display("FAIL flush: got haz=%b v0=%b stages=%b, want haz=0 v0=0 s0=0 s1=lw",
               h_obs, bus.valid_o[0], bus.ctrl_stages_o);
    end
    step(SW, 5'd1, 5'd2, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      step(IL, 5'd3, 5'd3, 1'b1, i[0]);
      exp_e = sb.pop_front();
      n_vec++;
      if (bus.ctrl_stages_o !== {10'b0011110000, 10'b0000000000, 10'b0010001000}
          || bus.valid_o !== 3'b101 || bus.illegal_o !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold flush=%0d: got stages=%b valid=%b ill=%b, want lw/0/sw 101 0",
                 i, bus.ctrl_stages_o, bus.valid_o, bus.illegal_o);
      end
    end
  endtask

  task automatic test_illegal();
    step(IL, 5'd1, 5'd2, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    n_vec++;
    if (bus.illegal_o !== 1'b1 || bus.valid_o[0] !== 1'b1 || bus.ctrl_stages_o[9:0] !== 10'd0) begin
      n_err++;
      $display("FAIL illegal_pulse: got ill=%b v0=%b s0=%b, want ill=1 v0=1 s0=0",
               bus.illegal_o, bus.valid_o[0], bus.ctrl_stages_o[9:0]);
    end
    step(RT, 5'd1, 5'd2, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    n_vec++;
    if (bus.illegal_o !== 1'b0 || bus.illegal_o !== exp_e.ill) begin
      n_err++;
      $display("FAIL illegal_one_cycle: got ill=%b, want 0", bus.illegal_o);
    end
    step(IL, 5'd1, 5'd2, 1'b0, 1'b1);
    exp_e = sb.pop_front();
    got   = '{v: bus.valid_o[0], w: bus.ctrl_stages_o[9:0], ill: bus.illegal_o};
    n_vec++;
    if (got !== exp_e || bus.illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_flush: got ill=%b v0=%b s0=%b, want ill=0 v0=0 s0=0",
               got.ill, got.v, got.w);
    end
  endtask

  task automatic test_reset_mid();
    step(RT, 5'd1, 5'd2, 1'b0, 1'b0);
    step(NT, 5'd1, 5'd2, 1'b0, 1'b0);
    step(IL, 5'd1, 5'd2, 1'b0, 1'b0);
    bus.stall_i = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({bus.ctrl_stages_o, bus.valid_o, bus.illegal_o} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_mid: got stages=%b valid=%b ill=%b, want all 0",
               bus.ctrl_stages_o, bus.valid_o, bus.illegal_o);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(BQ, 5'd1, 5'd2, 1'b0, 1'b0);
    exp_e = sb.pop_front();
    n_vec++;
    if (bus.ctrl_stages_o !== {20'd0, 10'b0000000101} || bus.valid_o !== 3'b001) begin
      n_err++;
      $display("FAIL reset_restart: got stages=%b valid=%b, want 0/0/beq valid 001",
               bus.ctrl_stages_o, bus.valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_flow();
    test_load_use();
    test_flush_stall();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
